// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / interrupt / ERET sequencer between the commit stage
// and CP0. Prioritises the committing instruction's events, issues a single
// CP0 write (or EXL-clear) pulse, flushes the pipe for FLUSH_CYCLES cycles,
// then offers the redirect target to fetch until it is accepted.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic        ex_adel_if,
    input  logic        ex_ri,
    input  logic        ex_sys,
    input  logic        ex_bp,
    input  logic        ex_ov,
    input  logic        ex_adel,
    input  logic        ex_ades,
    input  logic [31:0] ex_badvaddr,
    input  logic        ex_eret,
    input  logic        int_req,
    input  logic        cp0_exl,
    input  logic [31:0] cp0_ret_addr,
    output logic        cp0_exc,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        exc_q, exc_d;
    logic        eret_q, eret_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] target_q, target_d;

    logic        int_take;
    logic        any_flag;
    logic        exc_take;
    logic [4:0]  sel_code;
    logic [31:0] sel_badv;

    // Event qualification and fixed-priority ExcCode / BadVAddr selection
    always_comb begin
        int_take = int_req & ~cp0_exl;
        any_flag = ex_adel_if | ex_ri | ex_sys | ex_bp | ex_ov | ex_adel | ex_ades;
        exc_take = ex_valid & (any_flag | int_take);
        sel_code = 5'h00;
        sel_badv = 32'h0;
        if (int_take) begin
            sel_code = 5'h00;
        end else if (ex_adel_if) begin
            sel_code = 5'h04;
            sel_badv = ex_pc;
        end else if (ex_ri) begin
            sel_code = 5'h0a;
        end else if (ex_sys) begin
            sel_code = 5'h08;
        end else if (ex_bp) begin
            sel_code = 5'h09;
        end else if (ex_ov) begin
            sel_code = 5'h0c;
        end else if (ex_adel) begin
            sel_code = 5'h04;
            sel_badv = ex_badvaddr;
        end else if (ex_ades) begin
            sel_code = 5'h05;
            sel_badv = ex_badvaddr;
        end
    end

    // Sequencer: IDLE samples commit events, FLUSH counts down, REDIRECT handshakes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exc_d    = 1'b0;
        eret_d   = 1'b0;
        code_d   = code_q;
        epc_d    = epc_q;
        bd_d     = bd_q;
        badv_d   = badv_q;
        target_d = target_q;
        case (state_q)
            S_IDLE: begin
                if (exc_take) begin
                    exc_d    = 1'b1;
                    code_d   = sel_code;
                    epc_d    = ex_bd ? (ex_pc - 32'd4) : ex_pc;
                    bd_d     = ex_bd;
                    badv_d   = sel_badv;
                    target_d = EXC_VECTOR;
                    cnt_d    = FLUSH_LOAD;
                    state_d  = S_FLUSH;
                end else if (ex_valid & ex_eret) begin
                    // ERET leaves the exception fields untouched
                    eret_d   = 1'b1;
                    target_d = cp0_ret_addr;
                    cnt_d    = FLUSH_LOAD;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                // Last flush cycle: counter reaches 0 as we leave
                if (cnt_q <= 4'd1) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-field registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            exc_q    <= 1'b0;
            eret_q   <= 1'b0;
            code_q   <= 5'h00;
            epc_q    <= 32'h0;
            bd_q     <= 1'b0;
            badv_q   <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exc_q    <= exc_d;
            eret_q   <= eret_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
            badv_q   <= badv_d;
            target_q <= target_d;
        end
    end

    assign cp0_exc        = exc_q;
    assign cp0_eret       = eret_q;
    assign cp0_exccode    = code_q;
    assign cp0_epc        = epc_q;
    assign cp0_bd         = bd_q;
    assign cp0_badvaddr   = badv_q;
    assign flush          = (state_q == S_FLUSH);
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = target_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a cycle-level reference model pushes the
// expected CP0 pulses and redirect targets; a negedge monitor pops and checks.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          F   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_bd, ex_adel_if, ex_ri, ex_sys, ex_bp, ex_ov, ex_adel, ex_ades;
    logic        ex_eret, int_req, cp0_exl, redirect_ready;
    logic [31:0] ex_pc, ex_badvaddr, cp0_ret_addr;
    logic        cp0_exc, cp0_bd, cp0_eret, flush, redirect_valid, busy;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_bd(ex_bd),
        .ex_adel_if(ex_adel_if), .ex_ri(ex_ri), .ex_sys(ex_sys), .ex_bp(ex_bp),
        .ex_ov(ex_ov), .ex_adel(ex_adel), .ex_ades(ex_ades), .ex_badvaddr(ex_badvaddr),
        .ex_eret(ex_eret), .int_req(int_req), .cp0_exl(cp0_exl), .cp0_ret_addr(cp0_ret_addr),
        .cp0_exc(cp0_exc), .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
        .cp0_badvaddr(cp0_badvaddr), .cp0_eret(cp0_eret), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_exc;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] bv;
    } pulse_t;

    pulse_t      pq[$];
    logic [31:0] rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state: cycles since the event, and latched values
    bit          m_active = 0;
    int          m_age = 0;
    logic [4:0]  m_code = 0;
    logic [31:0] m_epc = 0, m_bv = 0, m_target = 0;
    logic        m_bd = 0;
    bit          exp_busy = 0, exp_flush = 0, exp_rv = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: evaluated on every rising edge from the sampled inputs
    initial begin
        logic        flg[8];
        logic [4:0]  codes[8];
        int          hit;
        pulse_t      p;
        codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_active = 0;
                m_code = 0; m_epc = 0; m_bd = 0; m_bv = 0; m_target = 0;
                rq.delete();
            end else if (m_active) begin
                if (m_age >= F && redirect_ready) m_active = 0;
                else m_age++;
            end else if (ex_valid) begin
                flg = '{int_req & ~cp0_exl, ex_adel_if, ex_ri, ex_sys, ex_bp, ex_ov, ex_adel, ex_ades};
                hit = -1;
                for (int i = 7; i >= 0; i--) if (flg[i]) hit = i;
                if (hit >= 0) begin
                    m_code = codes[hit];
                    m_bv   = (hit == 1) ? ex_pc : (hit >= 6) ? ex_badvaddr : 32'h0;
                    m_epc  = ex_bd ? ex_pc - 32'd4 : ex_pc;
                    m_bd   = ex_bd;
                    m_target = VEC;
                    p = '{cyc, 1'b1, m_code, m_epc, m_bd, m_bv};
                    pq.push_back(p);
                    rq.push_back(VEC);
                    m_active = 1; m_age = 0;
                end else if (ex_eret) begin
                    m_target = cp0_ret_addr;
                    p = '{cyc, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0};
                    pq.push_back(p);
                    rq.push_back(cp0_ret_addr);
                    m_active = 1; m_age = 0;
                end
            end
            exp_busy  = m_active;
            exp_flush = m_active && m_age < F;
            exp_rv    = m_active && m_age >= F;
        end
    end

    // Monitor: compare DUT against the model mid-cycle
    initial begin
        pulse_t p;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("flush", 32'(flush), 32'(exp_flush));
                chk("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
                chk("redirect_pc", redirect_pc, m_target);
                chk("cp0_exccode", 32'(cp0_exccode), 32'(m_code));
                chk("cp0_epc", cp0_epc, m_epc);
                chk("cp0_bd", 32'(cp0_bd), 32'(m_bd));
                chk("cp0_badvaddr", cp0_badvaddr, m_bv);
                if (cp0_exc || cp0_eret) begin
                    if (pq.size() == 0) begin
                        chk("unexpected_pulse", {30'h0, cp0_exc, cp0_eret}, 32'h0);
                    end else begin
                        p = pq.pop_front();
                        chk("pulse_cycle", 32'(cyc), 32'(p.cyc));
                        chk("cp0_exc", 32'(cp0_exc), 32'(p.is_exc));
                        chk("cp0_eret", 32'(cp0_eret), 32'(!p.is_exc));
                        if (p.is_exc) begin
                            chk("pulse_code", 32'(cp0_exccode), 32'(p.code));
                            chk("pulse_epc", cp0_epc, p.epc);
                            chk("pulse_bd", 32'(cp0_bd), 32'(p.bd));
                            chk("pulse_badv", cp0_badvaddr, p.bv);
                        end
                    end
                end else if (pq.size() != 0 && pq[0].cyc < cyc) begin
                    p = pq.pop_front();
                    chk("missing_pulse", 32'(p.cyc), 32'(-1));
                end
                if (redirect_valid && redirect_ready && !rst) begin
                    if (rq.size() == 0) chk("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
                    else chk("handshake_pc", redirect_pc, rq.pop_front());
                end
            end
        end
    end

    task automatic clr();
        ex_valid = 0; ex_bd = 0; ex_adel_if = 0; ex_ri = 0; ex_sys = 0; ex_bp = 0;
        ex_ov = 0; ex_adel = 0; ex_ades = 0; ex_eret = 0; int_req = 0; cp0_exl = 0;
        ex_pc = 32'h0; ex_badvaddr = 32'h0; cp0_ret_addr = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for the model to return to idle with fetch ready
    task automatic drain();
        int n = 0;
        clr();
        redirect_ready = 1;
        while (m_active && n < 50) begin step(); n++; end
        if (m_active) chk("drain_timeout", 32'(n), 32'(0));
        step();
    endtask

    task automatic rnd_inputs();
        ex_valid = ($urandom % 2) == 0;
        ex_pc = $urandom & 32'hFFFF_FFFC;
        ex_bd = ($urandom % 4) == 0;
        ex_adel_if = ($urandom % 10) == 0; ex_ri = ($urandom % 10) == 0;
        ex_sys = ($urandom % 10) == 0; ex_bp = ($urandom % 10) == 0;
        ex_ov = ($urandom % 10) == 0; ex_adel = ($urandom % 10) == 0;
        ex_ades = ($urandom % 10) == 0;
        ex_badvaddr = $urandom;
        ex_eret = ($urandom % 4) == 0;
        int_req = ($urandom % 5) == 0;
        cp0_exl = ($urandom % 2) == 0;
        cp0_ret_addr = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        redirect_ready = 0;
        rst = 1;
        step(); step();
        mon_en = 1;
        step();
        rst = 0;
        step();

        // overflow, no delay slot
        ex_valid = 1; ex_ov = 1; ex_pc = 32'h80001000; redirect_ready = 1;
        step(); drain();

        // delay slot, RI beats AdES
        ex_valid = 1; ex_bd = 1; ex_pc = 32'h80002004; ex_ri = 1; ex_ades = 1;
        ex_badvaddr = 32'h1233;
        step(); drain();

        // delay slot at address 0 wraps; AdEL-fetch reports the PC
        ex_valid = 1; ex_bd = 1; ex_pc = 32'h0; ex_adel_if = 1; ex_ades = 1;
        step(); drain();

        // masked interrupt, then unmasked, then interrupt over Sys
        ex_valid = 1; int_req = 1; cp0_exl = 1;
        repeat (3) step();
        cp0_exl = 0;
        step(); drain();
        ex_valid = 1; int_req = 1; ex_sys = 1; ex_pc = 32'h80000040;
        step(); drain();

        // AdEL data and AdES use the data address
        ex_valid = 1; ex_adel = 1; ex_ades = 1; ex_badvaddr = 32'hDEAD0001;
        step(); drain();
        ex_valid = 1; ex_ades = 1; ex_badvaddr = 32'h00000007;
        step(); drain();

        // ERET, then ERET losing to Bp
        ex_valid = 1; ex_eret = 1; cp0_ret_addr = 32'h80003010;
        step(); drain();
        ex_valid = 1; ex_eret = 1; ex_bp = 1; cp0_ret_addr = 32'h80003010; ex_pc = 32'h80003100;
        step(); drain();

        // backpressure: fetch stalls while new events are presented
        redirect_ready = 0;
        ex_valid = 1; ex_sys = 1; ex_pc = 32'h80004000;
        step();
        for (int i = 0; i < F + 5; i++) begin
            rnd_inputs(); ex_valid = 1; ex_ov = 1;
            step();
        end
        drain();

        // reset in the middle of the flush
        ex_valid = 1; ex_ov = 1; ex_pc = 32'h80005000; redirect_ready = 1;
        step();
        clr(); rst = 1;
        step();
        rst = 0;
        step(); step();

        // randomised traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rnd_inputs();
            redirect_ready = ($urandom % 2) == 0;
            rst = ($urandom % 97) == 0;
            step();
        end
        rst = 0;
        drain();
        step(); step();

        chk("pulse_queue_empty", 32'(pq.size()), 32'(0));
        chk("redirect_queue_empty", 32'(rq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
